// File: rtl/mux_lut_logic_pipe_pkg.sv
// Shared constants and helpers for the mux-LUT logic pipeline.
// Truth-table names come from mux_lut_defs.vh.
package mux_lut_logic_pipe_pkg;

  `include "mux_lut_defs.vh"

  localparam int TT_W  = 4;
  localparam int SEL_W = 2;

  // Operand A is the select MSB, operand B the LSB.
  function automatic logic [SEL_W-1:0] lane_sel(input logic a_bit, input logic b_bit);
    return {a_bit, b_bit};
  endfunction

endpackage

// File: rtl/mux_lut_defs.vh
// Truth-table constants for the 4:1 mux LUT lanes; bit index is {a,b}.
// Pulled into mux_lut_logic_pipe_pkg so every user sees one definition.
`ifndef MUX_LUT_DEFS_VH
`define MUX_LUT_DEFS_VH

localparam logic [3:0] TT_OR     = 4'b1110;
localparam logic [3:0] TT_AND    = 4'b1000;
localparam logic [3:0] TT_XOR    = 4'b0110;
localparam logic [3:0] TT_NAND   = 4'b0111;
localparam logic [3:0] TT_NOR    = 4'b0001;
localparam logic [3:0] TT_XNOR   = 4'b1001;
localparam logic [3:0] TT_PASS_A = 4'b1100;
localparam logic [3:0] TT_PASS_B = 4'b1010;

`endif

// File: rtl/mux_lut_logic_pipe_mux4_lane.sv
// Single-bit 4:1 mux: the truth table is the data, the operand pair is the select.
module mux4_lane
  import mux_lut_logic_pipe_pkg::*;
(
  input  logic [TT_W-1:0]  tt,
  input  logic [SEL_W-1:0] sel,
  output logic             y
);

  assign y = tt[sel];

endmodule

// File: rtl/mux_lut_logic_pipe.sv
// Two-stage valid/ready pipeline applying a 2-input Boolean LUT per bit lane.
// Optional MUX_LUT_PARITY_EN adds a registered y_parity output.
module mux_lut_logic_pipe
  import mux_lut_logic_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TT_W-1:0]  tt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic [CNT_W-1:0] done_cnt
`ifdef MUX_LUT_PARITY_EN
  ,
  output logic             y_parity
`endif
);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic [TT_W-1:0]  s1_tt;
  logic [WIDTH-1:0] y_next;
  logic             s2_free;
  logic             s1_adv;
  logic             in_fire;
  logic             out_fire;

  // in_ready depends only on pipeline state and out_ready, never on in_valid.
  assign s2_free  = !out_valid || out_ready;
  assign s1_adv   = s1_valid && s2_free;
  assign in_ready = !s1_valid || s2_free;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
      mux4_lane u_lane (
        .tt  (s1_tt),
        .sel (lane_sel(s1_a[i], s1_b[i])),
        .y   (y_next[i])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tt    <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_a     <= a;
      s1_b     <= b;
      s1_tt    <= tt;
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // y is left at its last value when the output drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      y         <= '0;
    end else if (s1_adv) begin
      out_valid <= 1'b1;
      y         <= y_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (out_fire) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

`ifdef MUX_LUT_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_parity <= 1'b0;
    end else if (s1_adv) begin
      y_parity <= ^y_next;
    end
  end
`endif

endmodule

// File: tb/tb_mux_lut_logic_pipe.sv
// Self-checking bench for mux_lut_logic_pipe: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_mux_lut_logic_pipe;
  import mux_lut_logic_pipe_pkg::*;

  localparam int W   = 8;
  localparam int CW  = 16;
  localparam int CW2 = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    tt = '0;
  logic          in_ready, out_valid, in_ready2, out_valid2;
  logic [W-1:0]  y, y2;
  logic [CW-1:0] done_cnt;
  logic [CW2-1:0] done_cnt2;
`ifdef MUX_LUT_PARITY_EN
  logic          y_parity, y_parity2;
`endif

  mux_lut_logic_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .tt(tt), .out_valid(out_valid), .out_ready(out_ready),
    .y(y), .done_cnt(done_cnt)
`ifdef MUX_LUT_PARITY_EN
    , .y_parity(y_parity)
`endif
  );

  mux_lut_logic_pipe #(.WIDTH(W), .CNT_W(CW2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .a(a), .b(b), .tt(tt), .out_valid(out_valid2), .out_ready(out_ready),
    .y(y2), .done_cnt(done_cnt2)
`ifdef MUX_LUT_PARITY_EN
    , .y_parity(y_parity2)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [W-1:0] y;
    int           edge_no;
  } item_t;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   tt;
    logic [W-1:0] exp_y;
  } vec_t;

  item_t        q[$];
  logic [W-1:0] got_q[$];
  int           edges = 0;
  int unsigned  done_m = 0;
  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_y = '0;
  logic         exp_ov;
  logic         fired;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Sum of minterms: each truth-table bit enables one {a,b} combination.
  function automatic logic [W-1:0] ref_fn(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                          input logic [3:0] t);
    logic [W-1:0] r;
    r = ({W{t[0]}} & ~aa & ~bb) | ({W{t[1]}} & ~aa & bb) |
        ({W{t[2]}} &  aa & ~bb) | ({W{t[3]}} &  aa & bb);
    return r;
  endfunction

  // Reference model: in-flight beats in acceptance order; the oldest becomes
  // visible one edge after the edge that accepted it.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      done_m    = 0;
      hold_prev = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y", y, 0);
      chk("rst_done_cnt", done_cnt, 0);
      chk("rst_in_ready", in_ready, 1);
`ifdef MUX_LUT_PARITY_EN
      chk("rst_parity", y_parity, 0);
`endif
    end else begin
      exp_ov = (q.size() > 0) && ((edges - q[0].edge_no) >= 1);
      chk("out_valid", out_valid, exp_ov);
      chk("in_ready", in_ready, (q.size() < 2) ? 1 : out_ready);
      chk("done_cnt", done_cnt, done_m[CW-1:0]);
      chk("done_cnt_w2", done_cnt2, done_m[CW2-1:0]);
      if (hold_prev) chk("hold_y", y, prev_y);
`ifdef MUX_LUT_PARITY_EN
      chk("parity", y_parity, ^y);
`endif
      hold_prev = out_valid && !out_ready;
      prev_y    = y;
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: got y=%0h expected no output at %0t", y, $time);
        end else begin
          chk("y_order", y, q[0].y);
          void'(q.pop_front());
        end
        got_q.push_back(y);
        done_m++;
      end
      if (in_valid && in_ready) q.push_back('{ref_fn(a, b, tt), edges + 1});
      edges++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [3:0] t);
    a = aa; b = bb; tt = t; in_valid = 1'b1;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    total++;
    bad++;
    $display("FAIL send_timeout: got in_ready=0 for 100 cycles expected acceptance at %0t", $time);
    in_valid = 1'b0;
  endtask

  vec_t vecs[9];
  logic [W-1:0] bp_exp[4];
  logic [1:0]   wrap_exp[5];
  int unsigned  d0;

  initial begin
    vecs[0] = '{8'hF0, 8'h3C, TT_OR,     8'hFC};
    vecs[1] = '{8'hF0, 8'h3C, TT_AND,    8'h30};
    vecs[2] = '{8'hF0, 8'h3C, TT_XOR,    8'hCC};
    vecs[3] = '{8'hF0, 8'h3C, TT_NAND,   8'hCF};
    vecs[4] = '{8'hF0, 8'h3C, TT_PASS_B, 8'h3C};
    vecs[5] = '{8'hF0, 8'h3C, TT_NOR,    8'h03};
    vecs[6] = '{8'hF0, 8'h3C, TT_XNOR,   8'h33};
    vecs[7] = '{8'hF0, 8'h3C, TT_PASS_A, 8'hF0};
    vecs[8] = '{8'h00, 8'hFF, TT_XOR,    8'hFF};
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    rst_n = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    // Single beat latency: accepted at edge E, visible after E+1, retired at E+2.
    out_ready = 1'b1;
    a = 8'hF0; b = 8'h3C; tt = TT_OR; in_valid = 1'b1;
    @(negedge clk);
    chk("lat_accept", in_ready, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("lat_e1_valid", out_valid, 0);
    @(negedge clk);
    chk("lat_e2_valid", out_valid, 1);
    chk("lat_e2_y", y, 8'hFC);
`ifdef MUX_LUT_PARITY_EN
    chk("parity_fc", y_parity, 0);
`endif
    @(negedge clk);
    chk("lat_done", done_cnt, 1);
    chk("lat_drain", out_valid, 0);
    chk("lat_y_kept", y, 8'hFC);
    @(posedge clk); #1;

    // Vector table, streamed back to back.
    got_q.delete();
    for (int i = 0; i < 9; i++) send(vecs[i].a, vecs[i].b, vecs[i].tt);
    cyc(4);
    chk("sweep_count", got_q.size(), 9);
    for (int i = 0; i < 9; i++) begin
      if (i < got_q.size()) chk($sformatf("sweep_y%0d", i), got_q[i], vecs[i].exp_y);
    end
`ifdef MUX_LUT_PARITY_EN
    send(8'hF0, 8'h3C, TT_AND);
    @(negedge clk);
    chk("parity_30_y", y, 8'h30);
    chk("parity_30", y_parity, 0);
    @(posedge clk); #1;
    cyc(2);
`endif

    // Backpressure: four beats against a stalled consumer.
    got_q.delete();
    d0 = done_m;
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) bp_exp[k] = ref_fn(W'(8'h11 * (k + 1)), 8'h0F, TT_XOR);
    fork
      begin
        for (int k = 0; k < 4; k++) send(W'(8'h11 * (k + 1)), 8'h0F, TT_XOR);
      end
      begin
        cyc(4);
        @(negedge clk);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_y_first", y, bp_exp[0]);
        @(posedge clk); #1;
        cyc(3);
        out_ready = 1'b1;
      end
    join
    cyc(4);
    chk("bp_count", got_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (k < got_q.size()) chk($sformatf("bp_y%0d", k), got_q[k], bp_exp[k]);
    end
    chk("bp_done", done_cnt, CW'(d0 + 4));

    // Full pipe, output retires while a new beat enters on the same edge.
    got_q.delete();
    out_ready = 1'b0;
    send(8'hAA, 8'h55, TT_OR);
    send(8'hAA, 8'h55, TT_AND);
    a = 8'hAA; b = 8'h55; tt = TT_NAND; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    chk("sim_in_ready", in_ready, 1);
    chk("sim_out_valid", out_valid, 1);
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("sim_next_valid", out_valid, 1);
    chk("sim_next_y", y, 8'h00);
    @(posedge clk); #1;
    cyc(3);
    chk("sim_count", got_q.size(), 3);
    if (got_q.size() == 3) begin
      chk("sim_y0", got_q[0], 8'hFF);
      chk("sim_y1", got_q[1], 8'h00);
      chk("sim_y2", got_q[2], 8'hFF);
    end

    // Random traffic; a stalled beat keeps its operands until accepted.
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      fired = in_valid && in_ready;
      @(posedge clk); #1;
      if (!in_valid || fired) begin
        in_valid = ($urandom_range(0, 3) != 0);
        a  = W'($urandom);
        b  = W'($urandom);
        tt = 4'($urandom);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    cyc(5);
    chk("rand_drained", q.size(), 0);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    send(8'h0F, 8'hF0, TT_OR);
    send(8'h0F, 8'hF0, TT_XOR);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_y", y, 0);
    chk("mid_rst_done", done_cnt, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    cyc(2);
    rst_n = 1'b1;
    out_ready = 1'b1;
    got_q.delete();
    cyc(6);
    chk("mid_rst_no_stale", got_q.size(), 0);
    chk("mid_rst_done_after", done_cnt, 0);

    // Narrow counter wraps 1,2,3,0,1.
    for (int k = 0; k < 5; k++) begin
      send(W'(k), 8'hFF, TT_AND);
      cyc(2);
      @(negedge clk);
      chk($sformatf("wrap_%0d", k), done_cnt2, wrap_exp[k]);
      @(posedge clk); #1;
    end
    chk("wrap_wide", done_cnt, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
